// File: rtl/ctrl_redirect_sched.sv
// ctrl_redirect_sched
// Mispredict recovery sequencer for the control-ALU lane.
//
// Ports:
//   clk, reset         clock and synchronous active-high reset
//   ctrl*_i            resolved control result from control-ALU writeback
//   redirectReady_i    fetch accepts the pending redirect
//   redirectValid_o    redirect request pending (PENDING state)
//   redirectPC_o       redirect target (held register)
//   flush_o            one-cycle pulse, the cycle after a redirect is accepted
//   flushALid_o        age tag of the flushing branch; holds between pulses
//   stall_o            blocks control-lane issue while PENDING/RECOVER
//   bpUpd*_o           registered branch-predictor update packet
//   mispredCnt_o       saturating count of accepted redirects
//
// The oldest outstanding mispredict wins: while a redirect is held (or while
// recovering from a flush), only strictly older candidates may take over;
// younger or equal ones are wrong-path and dropped.
module ctrl_redirect_sched #(
    parameter int SIZE_PC        = 32,
    parameter int SIZE_AL_LOG    = 7,
    parameter int RECOVER_CYCLES = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   ctrlValid_i,
    input  logic                   ctrlMispredict_i,
    input  logic                   ctrlIsPredicted_i,
    input  logic                   ctrlDirection_i,
    input  logic [SIZE_PC-1:0]     ctrlPC_i,
    input  logic [SIZE_PC-1:0]     ctrlNextPC_i,
    input  logic [SIZE_AL_LOG:0]   ctrlALid_i,
    input  logic                   redirectReady_i,
    output logic                   redirectValid_o,
    output logic [SIZE_PC-1:0]     redirectPC_o,
    output logic                   flush_o,
    output logic [SIZE_AL_LOG:0]   flushALid_o,
    output logic                   stall_o,
    output logic                   bpUpdValid_o,
    output logic [SIZE_PC-1:0]     bpUpdPC_o,
    output logic                   bpUpdDir_o,
    output logic [31:0]            mispredCnt_o
);

    localparam int TAG_W = SIZE_AL_LOG + 1;
    localparam int CNT_W = (RECOVER_CYCLES > 0) ? $clog2(RECOVER_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PENDING = 2'd1,
        RECOVER = 2'd2
    } state_t;

    // Tags wrap around the active list; the MSB flips on each wrap, so with
    // differing wrap bits the larger index is the older entry.
    function automatic logic is_older(input logic [TAG_W-1:0] a, input logic [TAG_W-1:0] b);
        if (a[TAG_W-1] == b[TAG_W-1])
            return a[TAG_W-2:0] < b[TAG_W-2:0];
        else
            return a[TAG_W-2:0] > b[TAG_W-2:0];
    endfunction

    state_t             state_q, state_d;
    logic [SIZE_PC-1:0] held_pc_q, held_pc_d;
    logic [TAG_W-1:0]   held_tag_q, held_tag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TAG_W-1:0]   flush_tag_q;
    logic               flush_q;
    logic [31:0]        mispred_cnt_q;
    logic               candidate;
    logic               accept;

    assign candidate = ctrlValid_i & ctrlMispredict_i;

    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d    = state_q;
        held_pc_d  = held_pc_q;
        held_tag_d = held_tag_q;
        cnt_d      = cnt_q;
        accept     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (candidate) begin
                    state_d    = PENDING;
                    held_pc_d  = ctrlNextPC_i;
                    held_tag_d = ctrlALid_i;
                end
            end
            PENDING: begin
                accept = redirectReady_i;
                // An older candidate takes over the held slot whether or not
                // the current redirect is accepted; the accepted one still
                // flushes next cycle.
                if (candidate && is_older(ctrlALid_i, held_tag_q)) begin
                    held_pc_d  = ctrlNextPC_i;
                    held_tag_d = ctrlALid_i;
                end else if (accept) begin
                    state_d = (RECOVER_CYCLES == 0) ? IDLE : RECOVER;
                    cnt_d   = CNT_W'(RECOVER_CYCLES);
                end
            end
            RECOVER: begin
                if (candidate && is_older(ctrlALid_i, flush_tag_q)) begin
                    state_d    = PENDING;
                    held_pc_d  = ctrlNextPC_i;
                    held_tag_d = ctrlALid_i;
                end else if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of every other, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            held_pc_q     <= '0;
            held_tag_q    <= '0;
            cnt_q         <= '0;
            flush_q       <= 1'b0;
            flush_tag_q   <= '0;
            mispred_cnt_q <= '0;
            bpUpdValid_o  <= 1'b0;
            bpUpdPC_o     <= '0;
            bpUpdDir_o    <= 1'b0;
        end else begin
            state_q    <= state_d;
            held_pc_q  <= held_pc_d;
            held_tag_q <= held_tag_d;
            cnt_q      <= cnt_d;
            flush_q    <= accept;
            if (accept) begin
                flush_tag_q <= held_tag_q;
                if (mispred_cnt_q != '1)
                    mispred_cnt_q <= mispred_cnt_q + 32'd1;
            end
            // Predictor update runs regardless of recovery state.
            bpUpdValid_o <= ctrlValid_i & ctrlIsPredicted_i;
            if (ctrlValid_i && ctrlIsPredicted_i) begin
                bpUpdPC_o  <= ctrlPC_i;
                bpUpdDir_o <= ctrlDirection_i;
            end
        end
    end

    assign redirectValid_o = (state_q == PENDING);
    assign redirectPC_o    = held_pc_q;
    assign stall_o         = (state_q != IDLE);
    assign flush_o         = flush_q;
    assign flushALid_o     = flush_tag_q;
    assign mispredCnt_o    = mispred_cnt_q;

endmodule

// File: tb/tb_ctrl_redirect_sched.sv
module tb_ctrl_redirect_sched;

    logic        clk = 1'b0;
    logic        reset;
    logic        ctrlValid_i, ctrlMispredict_i, ctrlIsPredicted_i, ctrlDirection_i;
    logic [31:0] ctrlPC_i, ctrlNextPC_i;
    logic [7:0]  ctrlALid_i;
    logic        redirectReady_i;

    logic        redirectValid_o, flush_o, stall_o, bpUpdValid_o, bpUpdDir_o;
    logic [31:0] redirectPC_o, bpUpdPC_o, mispredCnt_o;
    logic [7:0]  flushALid_o;

    logic        z_redirectValid, z_flush, z_stall, z_bpUpdValid, z_bpUpdDir;
    logic [31:0] z_redirectPC, z_bpUpdPC, z_mispredCnt;
    logic [7:0]  z_flushALid;

    int tests = 0;
    int fails = 0;
    int exp_cnt = 0;

    always #5 clk = ~clk;

    ctrl_redirect_sched #(.SIZE_PC(32), .SIZE_AL_LOG(7), .RECOVER_CYCLES(3)) u_dut (
        .clk(clk), .reset(reset),
        .ctrlValid_i(ctrlValid_i), .ctrlMispredict_i(ctrlMispredict_i),
        .ctrlIsPredicted_i(ctrlIsPredicted_i), .ctrlDirection_i(ctrlDirection_i),
        .ctrlPC_i(ctrlPC_i), .ctrlNextPC_i(ctrlNextPC_i), .ctrlALid_i(ctrlALid_i),
        .redirectReady_i(redirectReady_i),
        .redirectValid_o(redirectValid_o), .redirectPC_o(redirectPC_o),
        .flush_o(flush_o), .flushALid_o(flushALid_o), .stall_o(stall_o),
        .bpUpdValid_o(bpUpdValid_o), .bpUpdPC_o(bpUpdPC_o), .bpUpdDir_o(bpUpdDir_o),
        .mispredCnt_o(mispredCnt_o)
    );

    ctrl_redirect_sched #(.SIZE_PC(32), .SIZE_AL_LOG(7), .RECOVER_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .ctrlValid_i(ctrlValid_i), .ctrlMispredict_i(ctrlMispredict_i),
        .ctrlIsPredicted_i(ctrlIsPredicted_i), .ctrlDirection_i(ctrlDirection_i),
        .ctrlPC_i(ctrlPC_i), .ctrlNextPC_i(ctrlNextPC_i), .ctrlALid_i(ctrlALid_i),
        .redirectReady_i(redirectReady_i),
        .redirectValid_o(z_redirectValid), .redirectPC_o(z_redirectPC),
        .flush_o(z_flush), .flushALid_o(z_flushALid), .stall_o(z_stall),
        .bpUpdValid_o(z_bpUpdValid), .bpUpdPC_o(z_bpUpdPC), .bpUpdDir_o(z_bpUpdDir),
        .mispredCnt_o(z_mispredCnt)
    );

    // Inputs change 1 ns after the rising edge; outputs are observed there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ctrlValid_i = 0; ctrlMispredict_i = 0; ctrlIsPredicted_i = 0; ctrlDirection_i = 0;
        ctrlPC_i = '0; ctrlNextPC_i = '0; ctrlALid_i = '0;
    endtask

    task automatic drive_cand(input logic [31:0] target, input logic [7:0] tag);
        ctrlValid_i = 1; ctrlMispredict_i = 1; ctrlNextPC_i = target; ctrlALid_i = tag;
    endtask

    task automatic test_reset();
        reset = 1; redirectReady_i = 0; clear_inputs();
        tick(); tick();
        reset = 0;
        tests++; if (redirectValid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", redirectValid_o); end
        tests++; if (flush_o !== 1'b0) begin fails++; $display("FAIL reset_flush: got %0b want 0", flush_o); end
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL reset_stall: got %0b want 0", stall_o); end
        tests++; if (mispredCnt_o !== 32'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", mispredCnt_o); end
        tests++; if (bpUpdValid_o !== 1'b0) begin fails++; $display("FAIL reset_bp: got %0b want 0", bpUpdValid_o); end
    endtask

    task automatic test_basic();
        drive_cand(32'h0040_0120, 8'h05); redirectReady_i = 1;
        tick(); clear_inputs();
        tests++; if (redirectValid_o !== 1'b1) begin fails++; $display("FAIL basic_valid: got %0b want 1", redirectValid_o); end
        tests++; if (redirectPC_o !== 32'h0040_0120) begin fails++; $display("FAIL basic_pc: got %h want 00400120", redirectPC_o); end
        tests++; if (flush_o !== 1'b0) begin fails++; $display("FAIL basic_noflush_early: got %0b want 0", flush_o); end
        tick(); exp_cnt++;
        tests++; if (flush_o !== 1'b1) begin fails++; $display("FAIL basic_flush: got %0b want 1", flush_o); end
        tests++; if (flushALid_o !== 8'h05) begin fails++; $display("FAIL basic_flush_tag: got %h want 05", flushALid_o); end
        tests++; if (redirectValid_o !== 1'b0) begin fails++; $display("FAIL basic_valid_drop: got %0b want 0", redirectValid_o); end
        tests++; if (mispredCnt_o !== 32'(exp_cnt)) begin fails++; $display("FAIL basic_cnt: got %0d want %0d", mispredCnt_o, exp_cnt); end
        redirectReady_i = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++; if (stall_o !== 1'b1 || flush_o !== 1'b0) begin fails++; $display("FAIL basic_recover%0d: stall %0b flush %0b want 1 0", i, stall_o, flush_o); end
        end
        tick();
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL basic_idle_stall: got %0b want 0", stall_o); end
        tests++; if (flushALid_o !== 8'h05) begin fails++; $display("FAIL basic_tag_hold: got %h want 05", flushALid_o); end
    endtask

    // Accept the held redirect, then sit through the 3-cycle recovery.
    task automatic accept_and_recover(input logic [7:0] tag, input string name);
        clear_inputs(); redirectReady_i = 1;
        tick(); exp_cnt++; redirectReady_i = 0;
        tests++; if (flush_o !== 1'b1 || flushALid_o !== tag) begin fails++; $display("FAIL %s_flush: flush %0b tag %h want 1 %h", name, flush_o, flushALid_o, tag); end
        tests++; if (mispredCnt_o !== 32'(exp_cnt)) begin fails++; $display("FAIL %s_cnt: got %0d want %0d", name, mispredCnt_o, exp_cnt); end
        repeat (4) tick();
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL %s_idle: stall %0b want 0", name, stall_o); end
    endtask

    task automatic test_replace();
        redirectReady_i = 0;
        drive_cand(32'h0000_1000, 8'h10); tick();
        drive_cand(32'h0000_2000, 8'h08); tick();
        tests++; if (redirectPC_o !== 32'h0000_2000) begin fails++; $display("FAIL replace_older: got %h want 00002000", redirectPC_o); end
        drive_cand(32'h0000_3000, 8'h20); tick();
        tests++; if (redirectPC_o !== 32'h0000_2000 || redirectValid_o !== 1'b1) begin fails++; $display("FAIL replace_younger: pc %h valid %0b want 00002000 1", redirectPC_o, redirectValid_o); end
        accept_and_recover(8'h08, "replace");
    endtask

    task automatic test_wrap();
        drive_cand(32'h0000_5000, 8'h05); tick();
        drive_cand(32'h0000_6000, 8'h85); tick();
        tests++; if (redirectPC_o !== 32'h0000_5000) begin fails++; $display("FAIL wrap_equal_idx: got %h want 00005000", redirectPC_o); end
        drive_cand(32'h0000_7000, 8'hFE); tick();
        tests++; if (redirectPC_o !== 32'h0000_7000) begin fails++; $display("FAIL wrap_older: got %h want 00007000", redirectPC_o); end
        accept_and_recover(8'hFE, "wrap");
    endtask

    task automatic test_back_to_back();
        drive_cand(32'h0000_8000, 8'h30); tick();
        drive_cand(32'h0000_9000, 8'h2F); redirectReady_i = 1;
        tick(); exp_cnt++; clear_inputs(); redirectReady_i = 0;
        tests++; if (flush_o !== 1'b1 || flushALid_o !== 8'h30) begin fails++; $display("FAIL simul_flush: flush %0b tag %h want 1 30", flush_o, flushALid_o); end
        tests++; if (redirectValid_o !== 1'b1 || redirectPC_o !== 32'h0000_9000) begin fails++; $display("FAIL simul_pending: valid %0b pc %h want 1 00009000", redirectValid_o, redirectPC_o); end
        tick();
        tests++; if (flush_o !== 1'b0) begin fails++; $display("FAIL simul_pulse_width: got %0b want 0", flush_o); end
        accept_and_recover(8'h2F, "simul");
    endtask

    task automatic test_recover_predictor();
        drive_cand(32'h0000_A000, 8'h30); tick();
        clear_inputs(); redirectReady_i = 1; tick(); exp_cnt++; redirectReady_i = 0;
        // Younger mispredict plus a predicted branch during recovery.
        drive_cand(32'h0000_B000, 8'h40);
        ctrlIsPredicted_i = 1; ctrlDirection_i = 1; ctrlPC_i = 32'h0040_0200;
        tick(); clear_inputs();
        tests++; if (bpUpdValid_o !== 1'b1 || bpUpdPC_o !== 32'h0040_0200 || bpUpdDir_o !== 1'b1) begin fails++; $display("FAIL bp_update: v %0b pc %h d %0b want 1 00400200 1", bpUpdValid_o, bpUpdPC_o, bpUpdDir_o); end
        tests++; if (redirectValid_o !== 1'b0 || stall_o !== 1'b1) begin fails++; $display("FAIL recover_drop: valid %0b stall %0b want 0 1", redirectValid_o, stall_o); end
        ctrlValid_i = 1; ctrlPC_i = 32'h0000_BEEF;
        tick(); clear_inputs();
        tests++; if (bpUpdValid_o !== 1'b0 || bpUpdPC_o !== 32'h0040_0200) begin fails++; $display("FAIL bp_hold: v %0b pc %h want 0 00400200", bpUpdValid_o, bpUpdPC_o); end
        tick();
        tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL recover_last: got %0b want 1", stall_o); end
        tick();
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL recover_end: got %0b want 0", stall_o); end
        // Older mispredict during recovery preempts the count.
        drive_cand(32'h0000_C000, 8'h50); tick();
        clear_inputs(); redirectReady_i = 1; tick(); exp_cnt++; redirectReady_i = 0;
        drive_cand(32'h0000_D000, 8'h48); tick();
        tests++; if (redirectValid_o !== 1'b1 || redirectPC_o !== 32'h0000_D000) begin fails++; $display("FAIL recover_older: valid %0b pc %h want 1 0000d000", redirectValid_o, redirectPC_o); end
        accept_and_recover(8'h48, "preempt");
    endtask

    task automatic test_reset_mid_pending();
        drive_cand(32'h0000_E000, 8'h01); tick(); clear_inputs();
        tests++; if (redirectValid_o !== 1'b1) begin fails++; $display("FAIL midreset_pre: got %0b want 1", redirectValid_o); end
        reset = 1; redirectReady_i = 1;
        tick();
        reset = 0; redirectReady_i = 0; exp_cnt = 0;
        tests++; if (redirectValid_o !== 1'b0 || stall_o !== 1'b0 || flush_o !== 1'b0) begin fails++; $display("FAIL midreset_ctrl: v %0b s %0b f %0b want 0 0 0", redirectValid_o, stall_o, flush_o); end
        tests++; if (mispredCnt_o !== 32'd0 || flushALid_o !== 8'h00 || redirectPC_o !== 32'd0) begin fails++; $display("FAIL midreset_data: cnt %0d tag %h pc %h want 0 00 0", mispredCnt_o, flushALid_o, redirectPC_o); end
        tick();
        tests++; if (flush_o !== 1'b0 || redirectValid_o !== 1'b0) begin fails++; $display("FAIL midreset_noflush: f %0b v %0b want 0 0", flush_o, redirectValid_o); end
    endtask

    task automatic test_no_recover();
        drive_cand(32'h0000_F000, 8'h02); tick(); clear_inputs();
        tests++; if (z_redirectValid !== 1'b1 || z_redirectPC !== 32'h0000_F000) begin fails++; $display("FAIL norec_pending: v %0b pc %h want 1 0000f000", z_redirectValid, z_redirectPC); end
        redirectReady_i = 1; tick(); redirectReady_i = 0;
        tests++; if (z_flush !== 1'b1 || z_flushALid !== 8'h02 || z_stall !== 1'b0 || z_redirectValid !== 1'b0) begin fails++; $display("FAIL norec_flush: f %0b tag %h s %0b v %0b want 1 02 0 0", z_flush, z_flushALid, z_stall, z_redirectValid); end
        tests++; if (z_mispredCnt !== 32'd1) begin fails++; $display("FAIL norec_cnt: got %0d want 1", z_mispredCnt); end
        tick();
        tests++; if (z_flush !== 1'b0 || z_stall !== 1'b0) begin fails++; $display("FAIL norec_idle: f %0b s %0b want 0 0", z_flush, z_stall); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_replace();
        test_wrap();
        test_back_to_back();
        test_recover_predictor();
        test_reset_mid_pending();
        test_no_recover();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ctrl_redirect_sched.md
Name: ctrl_redirect_sched

Overview:
- Sequences mispredict recovery for the control-ALU lane.
- Consumes per-cycle resolved control results (executed/mispredict/direction/nextPC) from the control-ALU writeback stage. Selects the oldest outstanding mispredict, holds a redirect request to fetch under a valid/ready handshake, then pulses a flush and stalls control-lane issue for a fixed recovery window.
- Also emits registered branch-predictor update packets for conditional branches.

Parameters:
SIZE_PC, 32, width of PCs and targets
SIZE_AL_LOG, 7, active-list index width; age tag is SIZE_AL_LOG+1 bits (MSB = wrap bit)
RECOVER_CYCLES, 3, stall cycles after the flush pulse (0 allowed)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
ctrlValid_i  in  1  control-ALU result valid this cycle (flags.executed)
ctrlMispredict_i  in  1  flags.mispredict of result
ctrlIsPredicted_i  in  1  flags.isPredicted (conditional branch or RET)
ctrlDirection_i  in  1  resolved direction
ctrlPC_i  in  SIZE_PC  PC of control instruction
ctrlNextPC_i  in  SIZE_PC  resolved next PC
ctrlALid_i  in  SIZE_AL_LOG+1  age tag {wrap, index}
redirectReady_i  in  1  fetch accepts redirect
redirectValid_o  out  1  redirect request pending
redirectPC_o  out  SIZE_PC  redirect target
flush_o  out  1  one-cycle flush pulse
flushALid_o  out  SIZE_AL_LOG+1  tag of flushing branch; younger entries are squashed
stall_o  out  1  block control-lane issue
bpUpdValid_o  out  1  predictor update valid
bpUpdPC_o  out  SIZE_PC  branch PC
bpUpdDir_o  out  1  resolved direction
mispredCnt_o  out  32  saturating count of accepted redirects

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named reset.
- Reset: all outputs 0, state IDLE, counters 0. Reset mid-PENDING/RECOVER discards the held redirect; no flush is issued.
- Age compare: A older than B iff (A.wrap==B.wrap) ? A.idx<B.idx : A.idx>B.idx. Equal tags are not older.
- "Candidate": ctrlValid_i & ctrlMispredict_i.
- States:
  - IDLE: candidate -> capture {ctrlNextPC_i, ctrlALid_i}, go PENDING next cycle.
  - PENDING: redirectValid_o=1, stall_o=1, redirectPC_o from held register.
    - No handshake: a candidate older than the held tag replaces the held PC/tag next cycle. Younger or equal candidates are dropped. This is the only case in which redirectPC_o may change while valid and not accepted.
    - Accept (redirectValid_o & redirectReady_i): next cycle flush_o=1 for exactly one cycle with flushALid_o = accepted tag, and mispredCnt_o increments, saturating at 0xFFFF_FFFF. Then go RECOVER with counter = RECOVER_CYCLES, or IDLE if RECOVER_CYCLES=0.
    - Accept and candidate in the same cycle: if the candidate is older than the accepted tag, the flush still issues for the accepted tag and the state goes PENDING with the candidate; otherwise the candidate is dropped.
  - RECOVER: stall_o=1, redirectValid_o=0, counter decrements each cycle.
    - Counter reaches 0 -> IDLE; stall_o deasserts in the IDLE cycle.
    - Candidate older than the last flushed tag -> PENDING with it, abandoning the count.
    - Younger or equal candidates are wrong-path and dropped.
- flushALid_o holds its value between pulses.
- Redirect latency: candidate in cycle N -> redirectValid_o in N+1 -> flush_o in cycle after accept.
- Predictor update:
  - If ctrlValid_i & ctrlIsPredicted_i in cycle N, then in N+1: bpUpdValid_o=1, bpUpdPC_o=ctrlPC_i, bpUpdDir_o=ctrlDirection_i.
  - Independent of state; registered, with no back-pressure.
  - bpUpdValid_o=0 otherwise; bpUpd data holds its last value.
- Non-mispredicting results affect only the predictor update path.

Test Plan:
- Basic: candidate at cycle 2 (PC target 0x0040_0120, tag 0x05), redirectReady_i=1 -> redirectValid_o=1 at 3; flush_o=1, flushALid_o=0x05 at 4; stall_o high cycles 3-7; IDLE at 8 (RECOVER_CYCLES=3); mispredCnt_o=1.
- Replace while stalled: ready=0, held tag 0x10. Candidate tag 0x08 -> redirectPC_o switches to its target. Candidate tag 0x20 -> ignored. Raise ready -> flushALid_o=0x08.
- Wrap compare: held tag 0x05 (wrap=0), candidate 0x85 (wrap=1, idx 5, equal -> not older) is dropped. Candidate 0xFE (wrap=1, idx 0x7E > 5 -> older) replaces it.
- Simultaneous: accept tag 0x30 while candidate tag 0x2F arrives -> flush 0x30 pulses, then PENDING with 0x2F, second flush later; mispredCnt_o=2.
- Recovery and predictor: during RECOVER, candidate 0x40 (younger than 0x30) is dropped and the stall ends on schedule. A BEQ result ctrlPC_i=0x0040_0200, dir=1, isPredicted=1 in cycle N gives bpUpdValid_o=1, bpUpdDir_o=1 in N+1.
- Reset mid-PENDING: assert reset with redirectValid_o=1 -> next cycle all outputs 0, no flush; RECOVER_CYCLES=0 build goes PENDING->IDLE directly after accept.
